// File: rtl/fpu_addsub_pkg.sv
// Shared types for the FPU add/sub sharing logic.
// Op encoding, in-flight tag layout and ID width helper.
package fpu_addsub_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } fpu_op_e;

  // Tag ID field is sized for up to 256 requesters;
  // the arbiter only uses the low id_w(NUM_REQ) bits.
  localparam int TAG_ID_W = 8;

  typedef struct packed {
    logic                vld;
    logic [TAG_ID_W-1:0] id;
  } fpu_tag_t;

  function automatic int id_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with an owned rotating pointer.
// Search starts at ptr; ptr moves past the winner on advance.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 2) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic          found;
  int            idx;

  // first valid request at or after ptr, wrapping
  always_comb begin
    grant = '0;
    win   = ptr;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        win        = PW'(idx);
        found      = 1'b1;
      end
    end
  end

  // pointer moves one past the accepted winner
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (int'(win) == N - 1) ? '0 : win + 1'b1;
    end
  end

endmodule

// File: rtl/fpu_addsub_arbiter.sv
// Shares one fixed-latency FPU add/sub between requesters.
// Tags each op with its requester ID and routes results back.
module fpu_addsub_arbiter
  import fpu_addsub_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int SIZE_DATA   = 32,
  parameter int FPU_LATENCY = 3
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_hold,
  input  logic [NUM_REQ-1:0]           i_req_valid,
  input  logic [NUM_REQ-1:0]           i_req_op,
  input  logic [NUM_REQ*SIZE_DATA-1:0] i_req_a,
  input  logic [NUM_REQ*SIZE_DATA-1:0] i_req_b,
  output logic [NUM_REQ-1:0]           o_req_ready,
  output logic                         o_fpu_valid,
  output logic                         o_fpu_op,
  output logic [SIZE_DATA-1:0]         o_fpu_a,
  output logic [SIZE_DATA-1:0]         o_fpu_b,
  input  logic                         i_fpu_valid,
  input  logic [SIZE_DATA-1:0]         i_fpu_result,
  output logic [NUM_REQ-1:0]           o_rsp_valid,
  output logic [SIZE_DATA-1:0]         o_rsp_data,
  output logic                         o_busy,
  output logic                         o_err
);

  localparam int ID_W  = id_w(NUM_REQ);
  localparam int CNT_W = $clog2(FPU_LATENCY + 3);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_REQ-1:0]   req_act;
  logic [NUM_REQ-1:0]   grant;
  logic                 accept;
  logic                 sel_op;
  logic [SIZE_DATA-1:0] sel_a;
  logic [SIZE_DATA-1:0] sel_b;
  logic [ID_W-1:0]      sel_id;
  logic [ID_W-1:0]      iss_id;
  fpu_tag_t             tag_q [FPU_LATENCY];
  fpu_tag_t             pop;
  logic                 hit;
  logic [NUM_REQ-1:0]   rsp_hot;
  logic [CNT_W-1:0]     cnt;

  assign req_act = i_hold ? '0 : i_req_valid;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_rr (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .req     (req_act),
    .advance (accept),
    .grant   (grant)
  );

  assign o_req_ready = grant;
  assign accept      = |grant;

  // one-hot operand select for the granted requester
  always_comb begin
    sel_op = 1'b0;
    sel_a  = '0;
    sel_b  = '0;
    sel_id = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        sel_op = i_req_op[k];
        sel_a  = i_req_a[k*SIZE_DATA +: SIZE_DATA];
        sel_b  = i_req_b[k*SIZE_DATA +: SIZE_DATA];
        sel_id = ID_W'(k);
      end
    end
  end

  // issue register; data holds when nothing is accepted
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_fpu_valid <= 1'b0;
      o_fpu_op    <= OP_ADD;
      o_fpu_a     <= '0;
      o_fpu_b     <= '0;
      iss_id      <= '0;
    end else begin
      o_fpu_valid <= accept;
      if (accept) begin
        o_fpu_op <= sel_op;
        o_fpu_a  <= sel_a;
        o_fpu_b  <= sel_b;
        iss_id   <= sel_id;
      end
    end
  end

  // tag shift register tracking the FPU pipeline
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < FPU_LATENCY; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      tag_q[0] <= '{vld: o_fpu_valid, id: TAG_ID_W'(iss_id)};
      for (int k = 1; k < FPU_LATENCY; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

  assign pop = tag_q[FPU_LATENCY-1];
  assign hit = i_fpu_valid & pop.vld;

  // decode the popped ID into a requester one-hot
  always_comb begin
    rsp_hot = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rsp_hot[k] = hit && (pop.id == TAG_ID_W'(k));
    end
  end

  // response register; data holds between results
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rsp_valid <= '0;
      o_rsp_data  <= '0;
    end else begin
      o_rsp_valid <= rsp_hot;
      if (hit) o_rsp_data <= i_fpu_result;
    end
  end

  // sticky error on result/tag disagreement
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_err <= 1'b0;
    end else if (i_fpu_valid != pop.vld) begin
      o_err <= 1'b1;
    end
  end

  // saturating count of ops between accept and response
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= '0;
    end else begin
      unique case ({accept, hit})
        2'b10:   if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
        2'b01:   if (cnt != '0) cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign o_busy = |cnt;

endmodule
